// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - program counter and instruction fetch stage
// Fetches one word per req/ack and hands it to decode over valid/ready.
module fetch_pc #(
  parameter int AW = 16,
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] load_addr,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_data,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [IW-1:0] instr,
  output logic [AW-1:0] instr_pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] pc;

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) pc <= load_addr;
          state <= FETCH;
        end
        FETCH: begin
          // A redirect wins over a same-cycle ack; the returned word is dropped.
          if (load) begin
            pc <= load_addr;
          end else if (imem_ack) begin
            instr       <= imem_data;
            instr_pc    <= pc;
            pc          <= pc + 1'b1;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (load) begin
            pc          <= load_addr;
            instr_valid <= 1'b0;
            state       <= FETCH;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        default: begin
          state       <= IDLE;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
